modrm_operand_decoder: RTL

- Byte-serial x86-64 operand decoder.
- Consumes the ModRM, SIB, displacement and immediate bytes that follow an opcode, one byte per cycle.
- Produces the register/memory operand fields (base, index, scale, displacement, immediate, has-flags) that the downstream instruction record and trace printer consume.
- Sits between the fetch byte queue and instruction-record assembly; the opcode front end starts it with REX/immediate context.

---
 rtl/modrm_operand_decoder.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/modrm_operand_decoder.sv
// Byte-serial x86-64 operand decoder: ModRM, SIB, displacement and immediate bytes in, operand fields out.
// Optional build macro: MODRM_RIPREL_EN (mod=00/rm=101 decodes as RIP-relative instead of absolute disp32).
module modrm_operand_decoder #(
  parameter int REG_W  = 5,
  parameter int RIP_ID = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [3:0]       rex,
  input  logic             has_modrm,
  input  logic [3:0]       imm_bytes,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_reg,
  output logic             out_rm_is_reg,
  output logic [REG_W-1:0] out_base_reg,
  output logic [REG_W-1:0] out_index_reg,
  output logic [1:0]       out_scale,
  output logic             out_mem_has_base,
  output logic             out_mem_has_index,
  output logic             out_mem_has_disp,
  output logic             out_has_imm,
  output logic [63:0]      out_disp,
  output logic [63:0]      out_immediate,
  output logic [3:0]       out_len,
  output logic             out_err
);

`ifdef MODRM_RIPREL_EN
  localparam bit RIPREL = 1'b1;
`else
  localparam bit RIPREL = 1'b0;
`endif
  localparam logic [REG_W-1:0] RIP_BASE = REG_W'(RIP_ID);

  typedef enum logic [2:0] {
    S_IDLE, S_MODRM, S_SIB, S_DISP, S_IMM, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [2:0] rex_reg;        // {R,X,B}; W has no effect on operand decode
  logic       rex_w_unused;
  logic [3:0] imm_len_reg;
  logic [1:0] mod_reg;
  logic [3:0] disp_len_reg;
  logic [3:0] idx_reg;

  logic       start_fire, byte_fire;
  logic [1:0] b_hi;
  logic [2:0] b_mid, b_lo;
  logic       imm_legal, start_err;
  logic [3:0] start_imm_len;
  logic       modrm_no_base, sib_no_base;
  logic [3:0] modrm_disp_len, sib_disp_len;
  logic [3:0] field_len;
  logic       field_last;
  state_t     tail_state;
  logic [63:0] disp_asm, imm_asm;

  function automatic logic [63:0] sext(input logic [63:0] v, input logic [3:0] n);
    case (n)
      4'd1:    return {{56{v[7]}}, v[7:0]};
      4'd2:    return {{48{v[15]}}, v[15:0]};
      4'd4:    return {{32{v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  assign rex_w_unused = rex[3];

  assign start_ready = (state_reg == S_IDLE);
  assign byte_ready  = (state_reg == S_MODRM) || (state_reg == S_SIB) ||
                       (state_reg == S_DISP)  || (state_reg == S_IMM);
  assign out_valid   = (state_reg == S_DONE);

  assign start_fire = start_valid && start_ready;
  assign byte_fire  = byte_valid && byte_ready;

  assign b_hi  = byte_data[7:6];
  assign b_mid = byte_data[5:3];
  assign b_lo  = byte_data[2:0];

  // Unsupported immediate lengths behave as "no immediate" but flag the result.
  assign imm_legal     = imm_bytes inside {4'd1, 4'd2, 4'd4, 4'd8};
  assign start_err     = !imm_legal && (imm_bytes != 4'd0);
  assign start_imm_len = imm_legal ? imm_bytes : 4'd0;

  assign modrm_no_base = (b_hi == 2'b00) && (b_lo == 3'b101);
  assign sib_no_base   = (mod_reg == 2'b00) && (b_lo == 3'b101);

  always_comb begin
    modrm_disp_len = 4'd0;
    if (b_hi == 2'b01)
      modrm_disp_len = 4'd1;
    else if (b_hi == 2'b10 || modrm_no_base)
      modrm_disp_len = 4'd4;
  end

  always_comb begin
    sib_disp_len = 4'd0;
    if (mod_reg == 2'b01)
      sib_disp_len = 4'd1;
    else if (mod_reg == 2'b10 || sib_no_base)
      sib_disp_len = 4'd4;
  end

  assign field_len  = (state_reg == S_IMM) ? imm_len_reg : disp_len_reg;
  assign field_last = (idx_reg == field_len - 4'd1);
  assign tail_state = (imm_len_reg != 4'd0) ? S_IMM : S_DONE;

  // Little-endian assembly: each byte lands at lane idx_reg of the field.
  assign disp_asm = out_disp      | ({56'd0, byte_data} << {idx_reg[2:0], 3'b000});
  assign imm_asm  = out_immediate | ({56'd0, byte_data} << {idx_reg[2:0], 3'b000});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_valid)
          state_next = has_modrm ? S_MODRM : ((start_imm_len != 4'd0) ? S_IMM : S_DONE);
      end
      S_MODRM: begin
        if (byte_valid) begin
          if (b_hi != 2'b11 && b_lo == 3'b100)
            state_next = S_SIB;
          else if (b_hi != 2'b11 && modrm_disp_len != 4'd0)
            state_next = S_DISP;
          else
            state_next = tail_state;
        end
      end
      S_SIB: begin
        if (byte_valid)
          state_next = (sib_disp_len != 4'd0) ? S_DISP : tail_state;
      end
      S_DISP: begin
        if (byte_valid && field_last)
          state_next = tail_state;
      end
      S_IMM: begin
        if (byte_valid && field_last)
          state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rex_reg           <= '0;
      imm_len_reg       <= '0;
      mod_reg           <= '0;
      disp_len_reg      <= '0;
      idx_reg           <= '0;
      out_reg           <= '0;
      out_rm_is_reg     <= 1'b0;
      out_base_reg      <= '0;
      out_index_reg     <= '0;
      out_scale         <= '0;
      out_mem_has_base  <= 1'b0;
      out_mem_has_index <= 1'b0;
      out_mem_has_disp  <= 1'b0;
      out_has_imm       <= 1'b0;
      out_disp          <= '0;
      out_immediate     <= '0;
      out_len           <= '0;
      out_err           <= 1'b0;
    end else if (start_fire) begin
      rex_reg           <= rex[2:0];
      imm_len_reg       <= start_imm_len;
      mod_reg           <= '0;
      disp_len_reg      <= '0;
      idx_reg           <= '0;
      out_reg           <= '0;
      out_rm_is_reg     <= 1'b0;
      out_base_reg      <= '0;
      out_index_reg     <= '0;
      out_scale         <= '0;
      out_mem_has_base  <= 1'b0;
      out_mem_has_index <= 1'b0;
      out_mem_has_disp  <= 1'b0;
      out_has_imm       <= 1'b0;
      out_disp          <= '0;
      out_immediate     <= '0;
      out_len           <= '0;
      out_err           <= start_err;
    end else if (byte_fire) begin
      out_len <= out_len + 4'd1;
      case (state_reg)
        S_MODRM: begin
          mod_reg      <= b_hi;
          out_reg      <= REG_W'({rex_reg[2], b_mid});
          disp_len_reg <= (b_hi == 2'b11) ? 4'd0 : modrm_disp_len;
          idx_reg      <= '0;
          if (b_hi == 2'b11) begin
            out_rm_is_reg <= 1'b1;
            out_base_reg  <= REG_W'({rex_reg[0], b_lo});
          end else if (b_lo == 3'b100) begin
            // base comes from the SIB byte
          end else if (modrm_no_base) begin
            out_mem_has_base <= RIPREL;
            out_base_reg     <= RIPREL ? RIP_BASE : '0;
          end else begin
            out_mem_has_base <= 1'b1;
            out_base_reg     <= REG_W'({rex_reg[0], b_lo});
          end
        end
        S_SIB: begin
          out_scale    <= b_hi;
          disp_len_reg <= sib_disp_len;
          // index 100 without REX.X means "no index"; with REX.X it is r12
          if ({rex_reg[1], b_mid} != 4'b0100) begin
            out_mem_has_index <= 1'b1;
            out_index_reg     <= REG_W'({rex_reg[1], b_mid});
          end
          if (!sib_no_base) begin
            out_mem_has_base <= 1'b1;
            out_base_reg     <= REG_W'({rex_reg[0], b_lo});
          end
        end
        S_DISP: begin
          out_mem_has_disp <= 1'b1;
          if (field_last) begin
            out_disp <= sext(disp_asm, disp_len_reg);
            idx_reg  <= '0;
          end else begin
            out_disp <= disp_asm;
            idx_reg  <= idx_reg + 4'd1;
          end
        end
        S_IMM: begin
          out_has_imm <= 1'b1;
          if (field_last) begin
            out_immediate <= sext(imm_asm, imm_len_reg);
            idx_reg       <= '0;
          end else begin
            out_immediate <= imm_asm;
            idx_reg       <= idx_reg + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
